// File: rtl/fetch_stage.sv
// Fetch stage: sequential PC generation, credit-limited in-order imem requests,
// a small instruction buffer feeding decode, and flush/redirect handling that
// discards responses still in flight when the redirect lands.
module fetch_stage #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter int               BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_npc,
  output logic            err_spurious
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]   r_occ;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_drop;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic            r_err;
  logic [XLEN-1:0] r_buf_instr [BUF_DEPTH];
  logic [XLEN-1:0] r_buf_pc    [BUF_DEPTH];

  logic            w_credit_ok;
  logic            w_req_fire;
  logic            w_rsp_fire;
  logic            w_keep;
  logic            w_pop;
  logic [XLEN-1:0] w_target;

  // Credits count both buffered entries and requests in flight, so a kept
  // response always has a free slot. Extra bit avoids any sum overflow.
  assign w_credit_ok = ({1'b0, r_occ} + {1'b0, r_out}) < (CW+1)'(BUF_DEPTH);

  // Held low during reset; gated by redirect so no stale request issues.
  assign imem_req_valid = rst_n & w_credit_ok & ~redirect_valid;
  assign imem_req_addr  = r_pc;

  assign w_req_fire = imem_req_valid & imem_req_ready;
  assign w_rsp_fire = imem_rsp_valid & (r_out != '0);
  // A response arriving in the redirect cycle belongs to the old stream.
  assign w_keep     = w_rsp_fire & (r_drop == '0) & ~redirect_valid;
  assign w_pop      = dec_valid & dec_ready & ~redirect_valid;

  // Low two bits of the redirect target are forced to zero.
  assign w_target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  assign dec_valid    = (r_occ != '0);
  assign dec_instr    = r_buf_instr[r_head];
  assign dec_pc       = r_buf_pc[r_head];
  assign dec_npc      = r_buf_pc[r_head] + XLEN'(4);
  assign err_spurious = r_err;

  // Fetch PC and the PC that the next kept response belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc     <= w_target;
      r_rsp_pc <= w_target;
    end else begin
      if (w_req_fire) r_pc <= r_pc + XLEN'(4);
      if (w_keep)     r_rsp_pc <= r_rsp_pc + XLEN'(4);
    end
  end

  // Outstanding and drop counters; every response retires one outstanding
  // request, and on redirect everything still in flight becomes stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_out <= r_out + CW'(w_req_fire) - CW'(w_rsp_fire);
      if (redirect_valid)
        r_drop <= r_out - CW'(w_rsp_fire);
      else if (w_rsp_fire && (r_drop != '0))
        r_drop <= r_drop - CW'(1);
    end
  end

  // Buffer occupancy and ring pointers; redirect empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else if (redirect_valid) begin
      r_occ  <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_occ  <= r_occ + CW'(w_keep) - CW'(w_pop);
      if (w_keep) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
    end
  end

  // Buffer storage; contents only matter where occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (w_keep) begin
      r_buf_instr[r_tail] <= imem_rsp_data;
      r_buf_pc[r_tail]    <= r_rsp_pc;
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (imem_rsp_valid && (r_out == '0))
      r_err <= 1'b1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an imem model returning instr_of(addr) in order, and a
// program-order reference (expected request/decode PCs, occupancy and stale
// counts tracked as plain integers and a queue of in-flight addresses).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_npc;
  logic        err_spurious;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_npc(dec_npc),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_req = 0;
  int          n_pop = 0;
  int          tb_occ = 0;
  int          tb_drop = 0;
  bit          tb_err = 1'b0;
  logic [31:0] exp_req = '0;
  logic [31:0] exp_dec = '0;
  logic [31:0] last_pop_pc = '0;
  logic [31:0] q_addr [$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED;
  endfunction

  task automatic clear_model();
    q_addr.delete();
    tb_occ = 0; tb_drop = 0; tb_err = 1'b0;
    exp_req = '0; exp_dec = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    rst_n = 1'b1;
  endtask

  // One clock of stimulus plus the reference model; entered and left at negedge.
  task automatic run_cycle(input bit redir, input logic [31:0] rpc, input bit rdy,
                           input bit rsp_en, input bit drdy, input bit spur);
    int   qs0;
    bit   rsp_now;
    bit   spur_now;
    bit   exp_rv;
    logic [31:0] tgt;
    qs0 = q_addr.size();
    redirect_valid = redir; redirect_pc = rpc; imem_req_ready = rdy; dec_ready = drdy;
    rsp_now  = rsp_en && (qs0 > 0);
    spur_now = spur && (qs0 == 0);
    imem_rsp_valid = rsp_now || spur_now;
    imem_rsp_data  = rsp_now ? instr_of(q_addr[0]) : 32'hDEAD_BEEF;
    if (rsp_now) void'(q_addr.pop_front());
    #1;
    exp_rv = !redir && ((qs0 + tb_occ) < 4);
    n_cmp++;
    if (imem_req_valid !== exp_rv) begin
      n_fail++; $display("FAIL req_valid: got %0b expected %0b (t=%0t)", imem_req_valid, exp_rv, $time);
    end
    n_cmp++;
    if (dec_valid !== (tb_occ != 0)) begin
      n_fail++; $display("FAIL dec_valid: got %0b expected %0b (t=%0t)", dec_valid, (tb_occ != 0), $time);
    end
    n_cmp++;
    if (err_spurious !== tb_err) begin
      n_fail++; $display("FAIL err_spurious: got %0b expected %0b (t=%0t)", err_spurious, tb_err, $time);
    end
    if (redir) tb_drop = qs0 - (rsp_now ? 1 : 0);
    if (imem_req_valid && rdy) begin
      n_cmp++;
      if (imem_req_addr !== exp_req) begin
        n_fail++; $display("FAIL req_addr: got %h expected %h (t=%0t)", imem_req_addr, exp_req, $time);
      end
      q_addr.push_back(imem_req_addr);
      exp_req = exp_req + 32'd4;
      n_req++;
    end
    if (dec_valid && drdy && !redir) begin
      n_cmp++;
      if (dec_pc !== exp_dec) begin
        n_fail++; $display("FAIL dec_pc: got %h expected %h (t=%0t)", dec_pc, exp_dec, $time);
      end
      n_cmp++;
      if (dec_npc !== exp_dec + 32'd4) begin
        n_fail++; $display("FAIL dec_npc: got %h expected %h (t=%0t)", dec_npc, exp_dec + 32'd4, $time);
      end
      n_cmp++;
      if (dec_instr !== instr_of(exp_dec)) begin
        n_fail++; $display("FAIL dec_instr: got %h expected %h (t=%0t)", dec_instr, instr_of(exp_dec), $time);
      end
      last_pop_pc = dec_pc;
      exp_dec = exp_dec + 32'd4;
      n_pop++;
      tb_occ--;
    end
    if (rsp_now && !redir && !(redir)) begin
      if (tb_drop > 0) tb_drop--;
      else tb_occ++;
    end
    if (spur_now) tb_err = 1'b1;
    if (redir) begin
      tgt = {rpc[31:2], 2'b00};
      exp_req = tgt; exp_dec = tgt; tb_occ = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %0b expected 0", imem_req_valid);
    end
    n_cmp++;
    if (dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_dec_valid: got %0b expected 0", dec_valid);
    end
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_first_req: got valid=%0b addr=%h expected valid=1 addr=0", imem_req_valid, imem_req_addr);
    end
    n_cmp++;
    if (dec_valid !== 1'b0 || err_spurious !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got dec_valid=%0b err=%0b expected 0 0", dec_valid, err_spurious);
    end
  endtask

  task automatic test_streaming();
    int p0;
    apply_reset();
    repeat (3) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    p0 = n_pop;
    repeat (20) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (n_pop - p0 != 20) begin
      n_fail++; $display("FAIL stream_throughput: got %0d pops expected 20", n_pop - p0);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    int p0;
    apply_reset();
    r0 = n_req;
    repeat (12) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (n_req - r0 != 4) begin
      n_fail++; $display("FAIL bp_req_count: got %0d expected 4", n_req - r0);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_req_valid: got %0b expected 0", imem_req_valid);
    end
    p0 = n_pop;
    repeat (12) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (n_pop - p0 != 12) begin
      n_fail++; $display("FAIL bp_resume_pops: got %0d expected 12", n_pop - p0);
    end
  endtask

  task automatic test_redirect_inflight();
    int p0;
    bit got;
    logic [31:0] first_pc;
    apply_reset();
    repeat (2) run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 32'h103, 1'b1, 1'b0, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_next_req: got valid=%0b addr=%h expected valid=1 addr=00000100", imem_req_valid, imem_req_addr);
    end
    p0 = n_pop; got = 1'b0; first_pc = '0;
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      if (!got && n_pop > p0) begin got = 1'b1; first_pc = last_pop_pc; end
    end
    n_cmp++;
    if (!got || first_pc !== 32'h100) begin
      n_fail++; $display("FAIL redir_first_dec: got seen=%0b pc=%h expected pc=00000100", got, first_pc);
    end
  endtask

  task automatic test_redirect_race();
    int p0;
    bit got;
    logic [31:0] first_pc;
    apply_reset();
    run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (dec_valid !== 1'b0) begin
      n_fail++; $display("FAIL race_buffer_empty: got dec_valid=%0b expected 0", dec_valid);
    end
    n_cmp++;
    if (tb_drop != 1) begin
      n_fail++; $display("FAIL race_stale_count: got %0d expected 1", tb_drop);
    end
    p0 = n_pop; got = 1'b0; first_pc = '0;
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      if (!got && n_pop > p0) begin got = 1'b1; first_pc = last_pop_pc; end
    end
    n_cmp++;
    if (!got || first_pc !== 32'h200) begin
      n_fail++; $display("FAIL race_first_dec: got seen=%0b pc=%h expected pc=00000200", got, first_pc);
    end
  endtask

  task automatic test_wrap_error();
    apply_reset();
    run_cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_target: got %h expected fffffffc", imem_req_addr);
    end
    run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    imem_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next_addr: got %h expected 00000000", imem_req_addr);
    end
    repeat (4) run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (err_spurious !== 1'b0) begin
      n_fail++; $display("FAIL err_before_spurious: got %0b expected 0", err_spurious);
    end
    run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (err_spurious !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %0b expected 1", err_spurious);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (err_spurious !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared_by_reset: got %0b expected 0", err_spurious);
    end
  endtask

  task automatic test_random();
    bit          redir;
    logic [31:0] rpc;
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      redir = ($urandom_range(24) == 0);
      rpc   = $urandom;
      run_cycle(redir, rpc, ($urandom_range(9) < 7), ($urandom_range(3) != 0),
                ($urandom_range(9) < 7), 1'b0);
    end
    repeat (12) run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_race();
    test_wrap_error();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
